led_seq_ctrl: RTL
=================

# led_seq_ctrl

Sequencing controller for the board LED register. It synchronises and debounces the 16 slide switches, then decodes a mode field. According to the mode, it drives the LEDs as a switch mirror, a rotating one-hot light, a full-bank blink, or a frozen hold. Step timing comes from an internal prescaled tick and a switch-programmable period. It sits between the top-level `sw_i` pins and `led_o`, replacing the direct switch-to-LED register.

## Interface
- `PRESCALE`, default 100000: clock cycles per tick; legal range ≥ 2.
- `DB_TICKS`, default 4: consecutive stable ticks required to accept a switch change; legal range ≥ 1.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `sw_i`  in  16  raw asynchronous switch inputs.
- `led_o`  out  16  registered LED drive.
- `tick_o`  out  1  one-cycle pulse on each prescaler wrap.
- `mode_o`  out  2  current debounced mode.

## Operation
- **Sync:** `sw_i` passes through a 2-flop synchroniser to produce `sw_s`.
- **Debounce:**
  - `cand` holds the last differing `sw_s`; `db_cnt` counts ticks.
  - If `sw_s != cand`: `cand <= sw_s` and `db_cnt <= 0`.
  - On a tick with `sw_s == cand`: `db_cnt++`.
  - When `db_cnt` reaches `DB_TICKS`: `sw_db <= cand` and `db_cnt` saturates.
- **Field decode of `sw_db`:**
  - mode = `[1:0]`, dir = `[2]` (0 = left, 1 = right), P = `[15:12]`.
  - step period = P+1 ticks.
- **Modes (FSM states):**
  - PASS (00): `led_o <= sw_db`, every cycle.
  - SHIFT (01): on entry, load `0x0001` (left) or `0x8000` (right). Each step rotates by 1 in dir. A dir change mid-mode reverses from the current position without reloading.
  - BLINK (10): on entry, `led_o <= 0xFFFF`. Each step inverts all bits.
  - HOLD (11): `led_o` keeps its value from the last cycle before entry.
- **Transitions:** any mode to any mode, taken the cycle after `sw_db` changes. Entry clears `step_cnt`.
- **Step generation:**
  - `step_cnt` increments on ticks.
  - On a tick with `step_cnt >= P`: step and `step_cnt <= 0`.
  - Lowering P below `step_cnt` therefore fires a step on the next tick.
  - `step_cnt` is frozen in PASS and HOLD.
- **Prescaler:** `pre_cnt` counts `0..PRESCALE-1` and wraps. `tick_o` = 1 exactly when `pre_cnt == PRESCALE-1`.
- **Asynchronous reset (`rst_i`), mid-operation included:**
  - `led_o = 0`, `tick_o = 0`, `mode_o = PASS`.
  - `sw_db`, `cand`, and the sync flops are 0.
  - All counters are 0.
  - After release, the debouncer must re-qualify the switches before `led_o` reflects them.

## Timing
- `sw_i` to `sw_s`: 2 cycles.
- `sw_db` update: registered on the cycle of the qualifying tick.
  - Total acceptance latency is 2 cycles + sync-to-next-tick alignment + `DB_TICKS` ticks.
- `sw_db` to `led_o` / `mode_o`: 1 cycle.
- SHIFT/BLINK steps land on `led_o` 1 cycle after the qualifying tick.
- A glitch shorter than `DB_TICKS` ticks never reaches `sw_db`.
- Mode entry and a step on the same cycle: entry wins; the step is discarded.
- Widths:
  - `pre_cnt` = `$clog2(PRESCALE)`.
  - `db_cnt` = `$clog2(DB_TICKS+1)`.
  - `step_cnt` = 4 bits; no overflow, since it clears at P ≤ 15.

## Structure
- **Package `led_ctrl_pkg`:**
  - `mode_e` enum: `MODE_PASS = 2'b00`, `MODE_SHIFT`, `MODE_BLINK`, `MODE_HOLD`.
  - Field-position localparams: `MODE_LSB = 0`, `DIR_BIT = 2`, `PER_LSB = 12`.
  - Entry constants: `SHIFT_INIT_L = 16'h0001`, `SHIFT_INIT_R = 16'h8000`.
- **Sub-module `sw_debounce`:**
  - Parameters: `W`, `DB_TICKS`.
  - Ports: `clk_i`, `rst_i`, `tick_i`, `raw_i[W]`, `db_o[W]`.
  - Holds the sync + debounce logic.
- **Top (`led_seq_ctrl`):** prescaler, mode FSM, step counter, LED register.

## Test plan
All scenarios use `PRESCALE=4` and `DB_TICKS=2`.

- **Reset:** assert `rst_i` mid-SHIFT at `led_o = 0x0010` → `led_o`, `mode_o`, and `tick_o` go to 0 immediately, with no clock edge needed; `tick_o` first pulses 4 cycles after release.
- **PASS:** hold `sw_i = 0xA5A4` steady → `led_o = 0xA5A4` within 2 + 4 + 8 cycles and stays there. A 3-cycle pulse to `0xFFFF` leaves `led_o` unchanged.
- **SHIFT:** `sw_i = 0x1001` (P = 1, left) → `led_o = 0x0001`, then `0x0002`, `0x0004`, … changing every 8 cycles; it wraps `0x8000` → `0x0001`. Setting dir (`sw_i = 0x1005`) continues rightward from the current bit.
- **BLINK:** `sw_i = 0x0002` (P = 0) → `led_o` alternates `0xFFFF` / `0x0000` every tick (4 cycles). Changing to `0xF002` stretches the interval to 64 cycles.
- **HOLD / period shrink:**
  - In SHIFT with P = 15 at `step_cnt = 10`, set P = 3 → a step occurs on the next tick.
  - Then switch the mode to HOLD → `led_o` freezes at its current value indefinitely.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED sequencing controller.
// Switch field positions, mode encoding and the rotate helper live here.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_SHIFT = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  localparam int MODE_LSB = 0;
  localparam int DIR_BIT  = 2;
  localparam int PER_LSB  = 12;

  localparam logic [15:0] SHIFT_INIT_L = 16'h0001;
  localparam logic [15:0] SHIFT_INIT_R = 16'h8000;

  // right = 1 moves the lit bit toward bit 0
  function automatic logic [15:0] rotate16(input logic [15:0] v, input logic right);
    return right ? {v[0], v[15:1]} : {v[14:0], v[15]};
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a tick-based debouncer.
// A value is accepted only after staying stable for DB_TICKS ticks.
module sw_debounce
  import led_ctrl_pkg::*;
#(
  parameter int W        = 16,
  parameter int DB_TICKS = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         tick_i,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] db_o
);

  localparam int            CW     = $clog2(DB_TICKS + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DB_TICKS);

  logic [W-1:0]  sync_q;
  logic [W-1:0]  sw_s;
  logic [W-1:0]  cand;
  logic [CW-1:0] db_cnt;

  // Any change in the synchronised value restarts qualification.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      sw_s   <= '0;
      cand   <= '0;
      db_cnt <= '0;
      db_o   <= '0;
    end else begin
      sync_q <= raw_i;
      sw_s   <= sync_q;
      if (sw_s != cand) begin
        cand   <= sw_s;
        db_cnt <= '0;
      end else if (tick_i && db_cnt != DB_MAX) begin
        db_cnt <= db_cnt + 1'b1;
        if (db_cnt == DB_MAX - 1'b1) begin
          db_o <= cand;
        end
      end
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencing controller: prescaler, debounced switch decode and mode FSM.
// Drives the LED bank as a mirror, rotating light, blink or frozen hold.
module led_seq_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int PRESCALE = 100000,
  parameter int DB_TICKS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] sw_i,
  output logic [15:0] led_o,
  output logic        tick_o,
  output logic [1:0]  mode_o
);

  localparam int            PW      = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [15:0]   sw_db;
  mode_e         mode_q;
  mode_e         mode_n;
  logic          dir;
  logic [3:0]    period;
  logic [3:0]    step_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_MAX) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign tick   = (pre_cnt == PRE_MAX);
  assign tick_o = tick;

  sw_debounce #(
    .W       (16),
    .DB_TICKS(DB_TICKS)
  ) u_debounce (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tick_i(tick),
    .raw_i (sw_i),
    .db_o  (sw_db)
  );

  assign mode_n = mode_e'(sw_db[MODE_LSB +: 2]);
  assign dir    = sw_db[DIR_BIT];
  assign period = sw_db[PER_LSB +: 4];
  assign mode_o = mode_q;

  // Mode entry takes priority over a step landing on the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q   <= MODE_PASS;
      led_o    <= '0;
      step_cnt <= '0;
    end else if (mode_n != mode_q) begin
      mode_q   <= mode_n;
      step_cnt <= '0;
      case (mode_n)
        MODE_PASS:  led_o <= sw_db;
        MODE_SHIFT: led_o <= dir ? SHIFT_INIT_R : SHIFT_INIT_L;
        MODE_BLINK: led_o <= 16'hFFFF;
        default:    led_o <= led_o;
      endcase
    end else begin
      case (mode_q)
        MODE_PASS: led_o <= sw_db;
        MODE_SHIFT, MODE_BLINK: begin
          if (tick) begin
            if (step_cnt >= period) begin
              step_cnt <= '0;
              led_o    <= (mode_q == MODE_SHIFT) ? rotate16(led_o, dir) : ~led_o;
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
